dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the MIPS pipeline's MEM stage. It accepts one word read or write per request from the pipeline, then holds the pipeline stalled for a fixed number of wait states. It completes the access against an internal 256×32 array, and returns read data with a one-cycle valid pulse. The block replaces the zero-latency data memory wherever slow-memory behaviour and stall handling must be exercised.

---
 rtl/mips_mem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the multi-cycle data-memory responder:
//   - state_e      : responder FSM states (IDLE, WAIT, RESP)
//   - ADDR_W_DEF   : default word-address width (256-word array)
//   - DATA_W_DEF   : default data word width
//   - WAIT_MAX     : largest legal WAIT_CYCLES value (fits the 4-bit counter)
//   - cnt_reload() : wait-counter load value for a given WAIT_CYCLES
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // The counter is loaded with WAIT_CYCLES-1 so that WAIT lasts exactly
  // WAIT_CYCLES cycles. Out-of-range values are clamped to WAIT_MAX.
  function automatic logic [CNT_W-1:0] cnt_reload(input int unsigned wait_cycles);
    int unsigned w;
    w = (wait_cycles > WAIT_MAX) ? WAIT_MAX : wait_cycles;
    return (w == 0) ? '0 : CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Synchronous-write, synchronous-read 2^ADDR_W x DATA_W RAM, no reset.
// Ports:
//   clk      in   clock
//   we_i     in   write enable (writes wdata_i to addr_i on the rising edge)
//   re_i     in   read enable (registers mem[addr_i] into rdata_o)
//   addr_i   in   word address
//   wdata_i  in   write data
//   rdata_o  out  registered read data; holds while re_i is low
// -----------------------------------------------------------------------------
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q       <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data memory for the MEM stage. Accepts one load/store, stalls
// the pipeline for WAIT_CYCLES wait states, commits against the internal
// array and pulses rvalid for one cycle on load completion.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   req     in   MEM stage holds a load/store this cycle
//   we      in   1 = store, 0 = load (qualified by req)
//   addr    in   word address
//   wdata   in   store data
//   busy    out  pipeline stall request
//   rvalid  out  one-cycle pulse: rdata holds completed load data
//   rdata   out  load data, held between loads
// -----------------------------------------------------------------------------
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [CNT_W-1:0] CNT_INIT = cnt_reload(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rdv_q;
  logic              accept;
  logic              commit;

  logic              mem_we, mem_re, acc_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The edge entering RESP is the commit edge; nothing commits in reset.
    commit = rst_n && (state_d == RESP);
  end

  // With zero wait states the commit edge is also the accept edge, so the
  // holding registers are not loaded yet and the live pins are used instead.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = we;
      mem_addr  = addr;
      mem_wdata = wdata;
    end else begin
      acc_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
    mem_we = commit &&  acc_we;
    mem_re = commit && !acc_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (mem_re) rdv_q <= 1'b1;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // The RAM read register has no reset; rdata reads as zero until the first
  // load after reset has completed.
  assign rdata  = rdv_q ? mem_rdata : '0;
  assign busy   = rst_n && ((state_q == IDLE) ? req : (state_q == WAIT));
  assign rvalid = (state_q == RESP) && !we_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_req, a_we, a_busy, a_rvalid;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;

  logic        z_req, z_we, z_busy, z_rvalid;
  logic [7:0]  z_addr;
  logic [31:0] z_wdata, z_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .req(a_req), .we(a_we), .addr(a_addr),
    .wdata(a_wdata), .busy(a_busy), .rvalid(a_rvalid), .rdata(a_rdata)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req(z_req), .we(z_we), .addr(z_addr),
    .wdata(z_wdata), .busy(z_busy), .rvalid(z_rvalid), .rdata(z_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus-only access: hold req for the whole access, drop it afterwards.
  task automatic acc(input bit zero, input bit wr, input logic [7:0] a, input logic [31:0] d);
    if (zero) begin
      z_req = 1'b1; z_we = wr; z_addr = a; z_wdata = d;
      repeat (2) step();
      z_req = 1'b0;
    end else begin
      a_req = 1'b1; a_we = wr; a_addr = a; a_wdata = d;
      repeat (4) step();
      a_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h00; a_wdata = 32'h0;
    z_req = 1'b1; z_we = 1'b1; z_addr = 8'h00; z_wdata = 32'h0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_w2: got %b expected 0", a_busy); end
    checks++; if (z_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_w0: got %b expected 0", z_busy); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid_w2: got %b expected 0", a_rvalid); end
    checks++; if (z_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid_w0: got %b expected 0", z_rvalid); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata_w2: got %h expected 0", a_rdata); end
    checks++; if (z_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata_w0: got %h expected 0", z_rdata); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rel_busy_w2: got %b expected 1", a_busy); end
    checks++; if (z_busy !== 1'b1) begin errors++; $display("FAIL rel_busy_w0: got %b expected 1", z_busy); end
    repeat (2) step();
    z_req = 1'b0;
    repeat (2) step();
    a_req = 1'b0;
  endtask

  task automatic test_store_load();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_busy !== (i < 3)) begin errors++; $display("FAIL st_busy[%0d]: got %b expected %b", i, a_busy, (i < 3)); end
      checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL st_rvalid[%0d]: got %b expected 0", i, a_rvalid); end
      step();
    end
    a_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_busy !== (i < 3)) begin errors++; $display("FAIL ld_busy[%0d]: got %b expected %b", i, a_busy, (i < 3)); end
      checks++; if (a_rvalid !== (i == 3)) begin errors++; $display("FAIL ld_rvalid[%0d]: got %b expected %b", i, a_rvalid, (i == 3)); end
      if (i == 3) begin
        checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata: got %h expected deadbeef", a_rdata); end
      end
      step();
    end
    a_req = 1'b0;
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL ld_pulse_end: got %b expected 0", a_rvalid); end
    checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata_hold: got %h expected deadbeef", a_rdata); end
    step();
  endtask

  task automatic test_wait0();
    acc(1'b1, 1'b1, 8'hFF, 32'h12345678);
    z_req = 1'b1; z_we = 1'b0; z_addr = 8'hFF;
    @(negedge clk);
    checks++; if (z_busy !== 1'b1) begin errors++; $display("FAIL w0_busy_acc: got %b expected 1", z_busy); end
    checks++; if (z_rvalid !== 1'b0) begin errors++; $display("FAIL w0_rvalid_acc: got %b expected 0", z_rvalid); end
    step();
    @(negedge clk);
    checks++; if (z_busy !== 1'b0) begin errors++; $display("FAIL w0_busy_resp: got %b expected 0", z_busy); end
    checks++; if (z_rvalid !== 1'b1) begin errors++; $display("FAIL w0_rvalid_resp: got %b expected 1", z_rvalid); end
    checks++; if (z_rdata !== 32'h12345678) begin errors++; $display("FAIL w0_rdata: got %h expected 12345678", z_rdata); end
    step();
    z_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    acc(1'b0, 1'b1, 8'h01, 32'h11111111);
    acc(1'b0, 1'b1, 8'h02, 32'h22222222);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) a_addr = 8'h02;
      @(negedge clk);
      checks++; if (a_busy !== ((i % 4) != 3)) begin errors++; $display("FAIL b2b_busy[%0d]: got %b expected %b", i, a_busy, ((i % 4) != 3)); end
      checks++; if (a_rvalid !== ((i % 4) == 3)) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", i, a_rvalid, ((i % 4) == 3)); end
      if (i == 3) begin
        checks++; if (a_rdata !== 32'h11111111) begin errors++; $display("FAIL b2b_rdata0: got %h expected 11111111", a_rdata); end
      end
      if (i == 7) begin
        checks++; if (a_rdata !== 32'h22222222) begin errors++; $display("FAIL b2b_rdata1: got %h expected 22222222", a_rdata); end
      end
      step();
    end
    a_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    acc(1'b0, 1'b1, 8'h20, 32'h00000007);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 32'hAAAA5555;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", a_busy); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata: got %h expected 0", a_rdata); end
    step();
    rst_n = 1'b1;
    a_req = 1'b0;
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h20;
    repeat (3) step();
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid: got %b expected 1", a_rvalid); end
    checks++; if (a_rdata !== 32'h00000007) begin errors++; $display("FAIL mid_rdata_after: got %h expected 00000007", a_rdata); end
    step();
    a_req = 1'b0;
  endtask

  task automatic test_hold();
    acc(1'b0, 1'b1, 8'h31, 32'h31313131);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 32'hCAFEF00D;
    step();
    a_addr = 8'h31; a_wdata = 32'h0BADBEEF;
    repeat (3) step();
    a_req = 1'b0;
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h30;
    repeat (3) step();
    @(negedge clk);
    checks++; if (a_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_addr30: got %h expected cafef00d", a_rdata); end
    step();
    a_addr = 8'h31;
    repeat (3) step();
    @(negedge clk);
    checks++; if (a_rdata !== 32'h31313131) begin errors++; $display("FAIL hold_addr31: got %h expected 31313131", a_rdata); end
    step();
    a_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wait0();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
